// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Measures the high time of a servo-style PWM input and converts it back to
//   the 8-bit position code used by the servo drivers:
//     width = MIN_WIDTH + pos*STEP (clk cycles)
//   The conversion is a repeated subtraction, so the block needs no divider
//   and no multiplier.
//
//   Ports:
//     clk        system clock (50 MHz)
//     reset      asynchronous, active-high reset
//     pwm_in     asynchronous PWM input
//     pos        last decoded position
//     pos_valid  one-cycle strobe, pos updated this cycle
//     raw_width  high width of the last accepted pulse, in clk cycles
//     pulse_err  sticky, last pulse was longer than MAX_HIGH
//     sig_lost   no rising edge seen for FRAME_TIMEOUT cycles
//
//   Build option:
//     SERVO_DEC_AVG_EN  when defined, pos is the rounded mean of this and the
//                       previous conversion. The first conversion after reset
//                       or after sig_lost is not averaged.
//
//   States:
//     WAIT_RISE | idle, waiting for a qualified rising edge
//     MEASURE   | counting high cycles
//     ERR_WAIT  | pulse too long, waiting for the input to go low
//     CONVERT   | repeated subtraction of STEP from (width - MIN_WIDTH)
//     OUTPUT    | publish pos, clear pulse_err/sig_lost
module servo_pwm_decoder #(
  parameter int MIN_WIDTH     = 29200,
  parameter int STEP          = 355,
  parameter int MAX_HIGH      = 150000,
  parameter int FRAME_TIMEOUT = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  pos,
  output logic        pos_valid,
  output logic [20:0] raw_width,
  output logic        pulse_err,
  output logic        sig_lost
);

  localparam logic [20:0] MIN_W  = 21'(MIN_WIDTH);
  localparam logic [20:0] STEP_W = 21'(STEP);
  localparam logic [20:0] MAX_W  = 21'(MAX_HIGH);
  localparam logic [21:0] TMO_W  = 22'(FRAME_TIMEOUT);

  typedef enum logic [2:0] {
    WAIT_RISE = 3'd0,
    MEASURE   = 3'd1,
    ERR_WAIT  = 3'd2,
    CONVERT   = 3'd3,
    OUTPUT    = 3'd4
  } state_t;

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [2:0]  prime_q;
  logic        rise, fall;
  logic [21:0] timer_q, timer_d;
  logic        timeout_hit;
  logic [20:0] cnt_q, rem_q, raw_width_q;
  logic [7:0]  q_q, pos_q, pos_d;
  logic        first_q, pos_valid_q, pulse_err_q, sig_lost_q;

`ifdef SERVO_DEC_AVG_EN
  logic [7:0]  prev_q;
  logic        have_prev_q;
  logic [8:0]  avg_sum;
`endif

  // Synchronizer plus edge-detect flop. prime_q marks when s2/s3 both hold
  // real samples; until then the reset zeros would fake a rise whenever the
  // input is already high as reset is released (a truncated pulse).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 3'b000;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  assign rise = prime_q[2] &  s2_q & ~s3_q;
  assign fall = prime_q[2] & ~s2_q &  s3_q;

  // Frame timer: cleared on every rise, otherwise counts up and saturates.
  always_comb begin
    timer_d = timer_q;
    if (rise)
      timer_d = 22'd0;
    else if (timer_q != {22{1'b1}})
      timer_d = timer_q + 22'd1;
  end

  // A rise on the same cycle as the timeout wins.
  assign timeout_hit = ~rise & (timer_d == TMO_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= 22'd0;
    else       timer_q <= timer_d;
  end

  // Value published in OUTPUT.
  always_comb begin
    pos_d = q_q;
`ifdef SERVO_DEC_AVG_EN
    avg_sum = {1'b0, q_q} + {1'b0, prev_q} + 9'd1;
    if (have_prev_q && !sig_lost_q)
      pos_d = avg_sum[8:1];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_RISE;
      cnt_q       <= 21'd0;
      rem_q       <= 21'd0;
      raw_width_q <= 21'd0;
      q_q         <= 8'd0;
      pos_q       <= 8'd0;
      first_q     <= 1'b0;
      pos_valid_q <= 1'b0;
      pulse_err_q <= 1'b0;
      sig_lost_q  <= 1'b0;
`ifdef SERVO_DEC_AVG_EN
      prev_q      <= 8'd0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      pos_valid_q <= 1'b0;
      if (timeout_hit)
        sig_lost_q <= 1'b1;

      case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            cnt_q   <= 21'd1;
            state_q <= MEASURE;
          end
        end

        MEASURE: begin
          if (fall) begin
            raw_width_q <= cnt_q;
            first_q     <= 1'b1;
            state_q     <= CONVERT;
          end else if (cnt_q >= MAX_W) begin
            // Still high after MAX_HIGH cycles: this is cycle MAX_HIGH+1.
            pulse_err_q <= 1'b1;
            state_q     <= ERR_WAIT;
          end else begin
            cnt_q <= cnt_q + 21'd1;
          end
        end

        ERR_WAIT: begin
          if (!s2_q)
            state_q <= WAIT_RISE;
        end

        CONVERT: begin
          if (first_q) begin
            first_q <= 1'b0;
            q_q     <= 8'd0;
            if (raw_width_q < MIN_W)
              state_q <= OUTPUT;
            else
              rem_q <= raw_width_q - MIN_W;
          end else if (rem_q >= STEP_W && q_q != 8'hFF) begin
            rem_q <= rem_q - STEP_W;
            q_q   <= q_q + 8'd1;
          end else begin
            state_q <= OUTPUT;
          end
        end

        OUTPUT: begin
          pos_q       <= pos_d;
          pos_valid_q <= 1'b1;
          pulse_err_q <= 1'b0;
          sig_lost_q  <= 1'b0;
`ifdef SERVO_DEC_AVG_EN
          prev_q      <= q_q;
          have_prev_q <= 1'b1;
`endif
          state_q     <= WAIT_RISE;
        end

        default: state_q <= WAIT_RISE;
      endcase
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign raw_width = raw_width_q;
  assign pulse_err = pulse_err_q;
  assign sig_lost  = sig_lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder, run with reduced timing parameters so
// whole frames fit in a short simulation:
//   MIN_WIDTH=40, STEP=3, MAX_HIGH=900, FRAME_TIMEOUT=3000.
// Those values keep the full position range, saturation, the too-long-pulse
// error and signal loss all reachable.
module tb_servo_pwm_decoder;

  localparam int MIN_W = 40;
  localparam int STEP  = 3;
  localparam int MAX_H = 900;
  localparam int TMO   = 3000;
  localparam int LOW_C = 300;
  localparam int LAT_MAX = 264;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_in = 1'b0;
  logic [7:0]  pos;
  logic        pos_valid;
  logic [20:0] raw_width;
  logic        pulse_err;
  logic        sig_lost;

  servo_pwm_decoder #(
    .MIN_WIDTH(MIN_W), .STEP(STEP), .MAX_HIGH(MAX_H), .FRAME_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .pos(pos),
    .pos_valid(pos_valid), .raw_width(raw_width),
    .pulse_err(pulse_err), .sig_lost(sig_lost)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pv_cnt = 0;
  int pv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (pos_valid) begin
      pv_cnt = pv_cnt + 1;
      pv_cyc = cyc;
    end

  // Expected visible state of the decoder.
  int m_pos, m_raw, m_err, m_lost, m_prev;
  bit m_first;

  typedef struct {
    int width;
    bit valid;
    int q;
  } vec_t;
  vec_t vecs[12];

  function automatic int model_q(int w);
    int q;
    if (w < MIN_W) return 0;
    q = (w - MIN_W) / STEP;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int shown_pos(int q);
    int p;
`ifdef SERVO_DEC_AVG_EN
    p = m_first ? q : (q + m_prev + 1) / 2;
`else
    p = q;
`endif
    m_prev  = q;
    m_first = 1'b0;
    return p;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_max(string name, int act, int lim);
    tests++;
    if (act > lim) begin
      fails++;
      $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
    end
  endtask

  task automatic check_state(string tag);
    check({tag, " pos"}, int'(pos), m_pos);
    check({tag, " raw_width"}, int'(raw_width), m_raw);
    check({tag, " pulse_err"}, int'(pulse_err), m_err);
    check({tag, " sig_lost"}, int'(sig_lost), m_lost);
  endtask

  task automatic do_frame(string tag, int w, bit exp_valid, int exp_q);
    int b, fall_c, nv;
    b = pv_cnt;
    pwm_in = 1'b1;
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    fall_c = cyc;
    repeat (LOW_C) @(negedge clk);
    nv = pv_cnt - b;
    check({tag, " pos_valid count"}, nv, exp_valid ? 1 : 0);
    if (exp_valid) begin
      check_max({tag, " latency"}, pv_cyc - fall_c, LAT_MAX);
      m_pos  = shown_pos(exp_q);
      m_raw  = w;
      m_err  = 0;
      m_lost = 0;
    end else begin
      m_err = 1;
    end
    check_state(tag);
  endtask

  initial begin
    int b, w;

    vecs[0]  = '{40,  1'b1, 0};
    vecs[1]  = '{41,  1'b1, 0};
    vecs[2]  = '{43,  1'b1, 1};
    vecs[3]  = '{86,  1'b1, 15};
    vecs[4]  = '{10,  1'b1, 0};
    vecs[5]  = '{805, 1'b1, 255};
    vecs[6]  = '{804, 1'b1, 254};
    vecs[7]  = '{850, 1'b1, 255};
    vecs[8]  = '{901, 1'b0, 0};
    vecs[9]  = '{900, 1'b1, 255};
    vecs[10] = '{1,   1'b1, 0};
    vecs[11] = '{520, 1'b1, 160};

    m_pos = 0; m_raw = 0; m_err = 0; m_lost = 0; m_prev = 0; m_first = 1'b1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pos_valid", int'(pos_valid), 0);
    check_state("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 12; i++)
      do_frame($sformatf("vec%0d w=%0d", i, vecs[i].width),
               vecs[i].width, vecs[i].valid, vecs[i].q);

    // Too-long pulse: error appears just after MAX_HIGH high cycles.
    b = pv_cnt;
    pwm_in = 1'b1;
    repeat (MAX_H - 3) @(negedge clk);
    check("err before limit", int'(pulse_err), 0);
    repeat (8) @(negedge clk);
    check("err after limit", int'(pulse_err), 1);
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (LOW_C) @(negedge clk);
    check("long pulse pos_valid count", pv_cnt - b, 0);
    m_err = 1;
    check_state("long pulse");

    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(1, 1000));
      do_frame($sformatf("rand%0d w=%0d", i, w), w, w <= MAX_H, model_q(w));
    end

    // Signal loss: one frame, then the line stays low.
    do_frame("pre-loss", 100, 1'b1, 20);
    repeat (TMO - 20 - (100 + LOW_C)) @(negedge clk);
    check("sig_lost before timeout", int'(sig_lost), 0);
    repeat (40) @(negedge clk);
    check("sig_lost after timeout", int'(sig_lost), 1);
    m_lost  = 1;
    m_first = 1'b1;
    do_frame("after loss", 340, 1'b1, 100);

    // Reset in the middle of a pulse; the tail of that pulse is ignored.
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    m_pos = 0; m_raw = 0; m_err = 0; m_lost = 0; m_first = 1'b1;
    check("mid reset pos_valid", int'(pos_valid), 0);
    check_state("mid reset");
    @(negedge clk);
    reset = 1'b0;
    b = pv_cnt;
    repeat (400) @(negedge clk);
    pwm_in = 1'b0;
    repeat (LOW_C) @(negedge clk);
    check("truncated pulse pos_valid count", pv_cnt - b, 0);
    check_state("truncated pulse");

    do_frame("post reset 100", 340, 1'b1, 100);
    do_frame("then 200", 640, 1'b1, 200);
`ifdef SERVO_DEC_AVG_EN
    check("averaged 100/200", int'(pos), 150);
`else
    check("unaveraged 200", int'(pos), 200);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
